alu_input_ctrl: RTL and testbench
=================================

ALU_INPUT_CTRL -- requirements
Module: alu_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a key change is accepted (10 ms at 50 MHz).
REQ-002 Parameter SYNC_STAGES, 2, synchronizer flop depth on every raw input.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 key_n  input  4  raw pushbuttons, active-low, bouncing.
REQ-006 sw  input  18  raw slide switches.
REQ-007 porta  output  32  operand A to ALU.
REQ-008 portb  output  32  operand B to ALU.
REQ-009 aluop  output  4  latched ALU operation code.
REQ-010 op_valid  output  1  one-cycle strobe: operands and aluop are a new committed operation.
REQ-011 state  output  2  current FSM state encoding, for LED display.

Function
REQ-012 Each key_n bit and each sw bit SHALL pass through SYNC_STAGES flops before use.
REQ-013 Each key SHALL be debounced independently: counter clears whenever synced value equals stable value; stable value takes synced value after DEBOUNCE_CYCLES consecutive differing cycles.
REQ-014 Press event SHALL be a one-cycle pulse on stable transition released(1)->pressed(0); release SHALL produce no event.
REQ-015 Raw press to event latency SHALL be SYNC_STAGES + DEBOUNCE_CYCLES cycles; register/state update one cycle after event.
REQ-016 Key roles: KEY0 load A, KEY1 load B, KEY2 execute, KEY3 clear.
REQ-017 Load value SHALL be sign extension {16{sw[16]}, sw[15:0]} of synced switches.
REQ-018 FSM states IDLE(0), GOT_A(1), READY(2), EXEC(3).
REQ-019 KEY0 in IDLE/GOT_A/READY: porta <= load value; IDLE->GOT_A, GOT_A and READY unchanged.
REQ-020 KEY1 in GOT_A/READY: portb <= load value; GOT_A->READY; KEY1 in IDLE SHALL be ignored.
REQ-021 KEY2 in READY: aluop <= synced sw[3:0], go to EXEC; KEY2 in IDLE/GOT_A SHALL be ignored.
REQ-022 EXEC SHALL last exactly one cycle with op_valid=1, then return to READY; op_valid=0 in all other states.
REQ-023 KEY3 in any state: porta, portb, aluop <= 0, state <= IDLE.
REQ-024 Simultaneous events priority KEY3 > KEY0 > KEY1 > KEY2; lower-priority events in the same cycle SHALL be dropped.
REQ-025 Events arriving while in EXEC SHALL be dropped.
REQ-026 Holding a key SHALL generate exactly one event per press.

Reset
REQ-027 RST SHALL asynchronously force porta=0, portb=0, aluop=0, op_valid=0, state=IDLE.
REQ-028 RST SHALL set key synchronizers and stable values to released (1), sw synchronizers to 0, debounce counters to 0.
REQ-029 No press event SHALL be produced in the first cycle after RST deassertion, even with a key held.

Structure
REQ-030 aluop_t and the FSM state enum SHALL live in the shared cpu_types_pkg; DEBOUNCE_CYCLES default as a package constant.
REQ-031 A sub-module key_debounce (sync + counter + edge detect, one bit) SHALL be instantiated four times.
REQ-032 Outputs SHALL be driven directly from flops, no combinational path from sw/key_n.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-033 Reset; sw=0x1_0005; hold KEY0 low 10 cycles -> porta=0xFFFF0005, state=1, one event only.
REQ-034 key_n[0] toggling every 2 cycles for 20 cycles -> no event, porta unchanged.
REQ-035 A=0x00000003, B=0x00000004, sw[3:0]=0x2, press KEY2 -> aluop=0x2, op_valid high exactly 1 cycle, state 3 then 2.
REQ-036 From reset press KEY1 with sw=0x0_00FF -> portb=0, state=0.
REQ-037 In READY, KEY3 and KEY0 events same cycle -> porta=portb=aluop=0, state=0.
REQ-038 RST asserted mid-debounce of KEY0 -> outputs zero immediately; after release no event, porta=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and constants for the ALU input controller: FSM state encoding,
// ALU opcode type and the switch-to-operand conversion.
package cpu_types_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int unsigned SW_WIDTH                = 18;

    typedef logic [3:0] aluop_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGotA  = 2'd1,
        StReady = 2'd2,
        StExec  = 2'd3
    } ctrl_state_e;

    // Switch 16 is the sign bit; switch 17 carries no operand meaning.
    function automatic logic [31:0] load_value(input logic [SW_WIDTH-1:0] sw);
        return {{16{sw[16]}}, sw[15:0]};
    endfunction

endpackage

// File: rtl/alu_input_ctrl_if.sv
// Board-side bundle of the ALU input controller: raw keys/switches in,
// committed operands, opcode and status out.
interface alu_input_ctrl_if;
    import cpu_types_pkg::*;

    logic [3:0]          key_n;
    logic [SW_WIDTH-1:0] sw;
    logic [31:0]         porta;
    logic [31:0]         portb;
    aluop_t              aluop;
    logic                op_valid;
    logic [1:0]          state;

    modport master (
        input  key_n,
        input  sw,
        output porta,
        output portb,
        output aluop,
        output op_valid,
        output state
    );

    modport slave (
        output key_n,
        output sw,
        input  porta,
        input  portb,
        input  aluop,
        input  op_valid,
        input  state
    );

endinterface

// File: rtl/key_debounce.sv
// One pushbutton: synchronizer, stability counter and a registered one-cycle
// pulse on the accepted released->pressed transition.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic CLK,
    input  logic RST,
    input  logic key_n_i,
    output logic press_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_q, press_d;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign press_o = press_q;

    always_comb begin
        sync_d[0] = key_n_i;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Any agreement with the stable value restarts the count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d    = '0;
            stable_d = synced;
            press_d  = ~synced;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q   <= '1;
            cnt_q    <= '0;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            press_q  <= press_d;
        end
    end

endmodule

// File: rtl/alu_input_ctrl.sv
// Turns debounced pushbutton presses and slide switches into committed ALU
// operands (A, B) and opcode, with a one-cycle op_valid strobe on execute.
module alu_input_ctrl
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input logic              CLK,
    input logic              RST,
    alu_input_ctrl_if.master bus
);

    logic [SW_WIDTH-1:0] sw_sync_q [SYNC_STAGES];
    logic [SW_WIDTH-1:0] sw_sync_d [SYNC_STAGES];
    logic [SW_WIDTH-1:0] sw_synced;
    logic [3:0]          press;

    ctrl_state_e state_q, state_d;
    logic [31:0] porta_q, porta_d;
    logic [31:0] portb_q, portb_d;
    aluop_t      aluop_q, aluop_d;
    logic        op_valid_q, op_valid_d;

    for (genvar k = 0; k < 4; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_key_debounce (
            .CLK     (CLK),
            .RST     (RST),
            .key_n_i (bus.key_n[k]),
            .press_o (press[k])
        );
    end

    always_comb begin
        sw_sync_d[0] = bus.sw;
        for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            sw_sync_d[i] = sw_sync_q[i-1];
        end
    end

    assign sw_synced = sw_sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sw_sync_q[i] <= '0;
            end
        end else begin
            sw_sync_q <= sw_sync_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // EXEC ignores every key, including clear; priority is KEY3 > KEY0 > KEY1 > KEY2.
    always_comb begin
        state_d = state_q;
        if (state_q == StExec) begin
            state_d = StReady;
        end else if (press[3]) begin
            state_d = StIdle;
        end else if (press[0]) begin
            if (state_q == StIdle) state_d = StGotA;
        end else if (press[1]) begin
            if (state_q == StGotA) state_d = StReady;
        end else if (press[2]) begin
            if (state_q == StReady) state_d = StExec;
        end
    end

    always_comb begin
        porta_d    = porta_q;
        portb_d    = portb_q;
        aluop_d    = aluop_q;
        op_valid_d = (state_d == StExec);
        if (state_q != StExec) begin
            if (press[3]) begin
                porta_d = '0;
                portb_d = '0;
                aluop_d = '0;
            end else if (press[0]) begin
                porta_d = load_value(sw_synced);
            end else if (press[1]) begin
                if (state_q != StIdle) portb_d = load_value(sw_synced);
            end else if (press[2]) begin
                if (state_q == StReady) aluop_d = sw_synced[3:0];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            porta_q    <= '0;
            portb_q    <= '0;
            aluop_q    <= '0;
            op_valid_q <= 1'b0;
        end else begin
            porta_q    <= porta_d;
            portb_q    <= portb_d;
            aluop_q    <= aluop_d;
            op_valid_q <= op_valid_d;
        end
    end

    assign bus.porta    = porta_q;
    assign bus.portb    = portb_q;
    assign bus.aluop    = aluop_q;
    assign bus.op_valid = op_valid_q;
    assign bus.state    = state_q;

endmodule

// File: tb/tb_alu_input_ctrl.sv
// Directed bench for alu_input_ctrl with a short debounce window.
module tb_alu_input_ctrl;

    logic CLK;
    logic RST;
    int   checks;
    int   passed;
    int   pulses;

    alu_input_ctrl_if bus ();

    alu_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (bus.op_valid === 1'b1) pulses <= pulses + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic press_key(input int k);
        bus.key_n[k] = 1'b0;
        tick(10);
        bus.key_n[k] = 1'b1;
        tick(10);
    endtask

    initial begin
        int n;
        checks    = 0;
        passed    = 0;
        pulses    = 0;
        RST       = 1'b1;
        bus.key_n = 4'hF;
        bus.sw    = '0;
        tick(2);
        chk("rst_porta", bus.porta, 32'h0);
        chk("rst_portb", bus.portb, 32'h0);
        chk("rst_aluop", {28'h0, bus.aluop}, 32'h0);
        chk("rst_op_valid", {31'h0, bus.op_valid}, 32'h0);
        chk("rst_state", {30'h0, bus.state}, 32'h0);
        RST = 1'b0;
        tick(2);

        // KEY1 in IDLE is ignored
        bus.sw = 18'h000FF;
        press_key(1);
        chk("idle_key1_portb", bus.portb, 32'h0);
        chk("idle_key1_state", {30'h0, bus.state}, 32'h0);

        // Held KEY0 loads sign-extended A exactly once
        bus.sw = 18'h10005;
        tick(3);
        bus.key_n[0] = 1'b0;
        tick(10);
        chk("load_a_porta", bus.porta, 32'hFFFF0005);
        chk("load_a_state", {30'h0, bus.state}, 32'h1);
        bus.sw = 18'h00007;
        tick(10);
        chk("hold_one_event", bus.porta, 32'hFFFF0005);
        bus.key_n[0] = 1'b1;
        tick(10);

        // Bouncing shorter than the window is rejected
        repeat (5) begin
            bus.key_n[0] = 1'b0;
            tick(2);
            bus.key_n[0] = 1'b1;
            tick(2);
        end
        tick(10);
        chk("bounce_porta", bus.porta, 32'hFFFF0005);
        chk("bounce_state", {30'h0, bus.state}, 32'h1);

        // A=3, B=4, execute with opcode 2
        bus.sw = 18'h00003;
        press_key(0);
        chk("a3_porta", bus.porta, 32'h3);
        chk("a3_state", {30'h0, bus.state}, 32'h1);
        bus.sw = 18'h00004;
        press_key(1);
        chk("b4_portb", bus.portb, 32'h4);
        chk("b4_state", {30'h0, bus.state}, 32'h2);
        bus.sw = 18'h00002;
        tick(3);
        pulses = 0;
        bus.key_n[2] = 1'b0;
        n = 0;
        while (bus.state !== 2'd3 && n < 20) begin
            tick(1);
            n++;
        end
        chk("exec_state", {30'h0, bus.state}, 32'h3);
        chk("exec_aluop", {28'h0, bus.aluop}, 32'h2);
        chk("exec_op_valid", {31'h0, bus.op_valid}, 32'h1);
        tick(1);
        chk("post_exec_state", {30'h0, bus.state}, 32'h2);
        chk("post_exec_op_valid", {31'h0, bus.op_valid}, 32'h0);
        tick(10);
        bus.key_n[2] = 1'b1;
        tick(10);
        chk("exec_pulse_count", pulses, 32'd1);
        chk("exec_aluop_held", {28'h0, bus.aluop}, 32'h2);

        // KEY3 and KEY0 together: clear wins
        bus.sw    = 18'h0ABCD;
        tick(3);
        bus.key_n = 4'b0110;
        tick(10);
        chk("clr_porta", bus.porta, 32'h0);
        chk("clr_portb", bus.portb, 32'h0);
        chk("clr_aluop", {28'h0, bus.aluop}, 32'h0);
        chk("clr_state", {30'h0, bus.state}, 32'h0);
        bus.key_n = 4'hF;
        tick(10);

        // Reset mid-debounce clears at once and loses the pending press
        bus.sw = 18'h00009;
        press_key(0);
        chk("pre_rst_porta", bus.porta, 32'h9);
        bus.key_n[0] = 1'b0;
        tick(3);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_porta", bus.porta, 32'h0);
        chk("async_rst_state", {30'h0, bus.state}, 32'h0);
        bus.key_n[0] = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(12);
        chk("post_rst_porta", bus.porta, 32'h0);
        chk("post_rst_state", {30'h0, bus.state}, 32'h0);

        // Key held across reset release: no immediate event, accepted after debounce
        bus.key_n[0] = 1'b0;
        RST = 1'b1;
        tick(2);
        RST = 1'b0;
        tick(1);
        chk("held_first_cycle_state", {30'h0, bus.state}, 32'h0);
        tick(10);
        chk("held_later_state", {30'h0, bus.state}, 32'h1);
        chk("held_later_porta", bus.porta, 32'h9);
        bus.key_n[0] = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
